ram_copy_engine: RTL and testbench

- Initiator for the 32 kB banked byte RAM (15-bit address: [14:10] bank, [9:0] offset; 8-bit data; single write-enable).
- Copies a block of `len` bytes from `src_addr` to `dst_addr` inside that RAM using the RAM's native read/write port.
- Sits beside the RAM as a bus master. A top-level mux gives it the port while `busy` is high.

---
 rtl/ram_pkg.sv | 39 +++
 rtl/ram_copy_engine_if.sv | 17 +
 rtl/ram_copy_engine.sv | 161 ++++++++++++++++
 tb/tb_ram_copy_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the banked byte RAM and its copy engine:
// geometry constants, bank/offset address split, the copy FSM state
// encoding and the RAM request payload.
package ram_pkg;

    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned MEM_BYTES = 32768;
    localparam int unsigned OFF_W     = 10;
    localparam int unsigned BANK_W    = ADDR_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE,
        ERR
    } state_e;

    // One RAM port request as driven by a master.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_req_t;

    // Bank select, address bits [14:10].
    function automatic logic [BANK_W-1:0] bank_sel(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFF_W];
    endfunction

    // Offset within a bank, address bits [9:0].
    function automatic logic [OFF_W-1:0] bank_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/ram_copy_engine_if.sv
// Native RAM read/write port.
//   we    : write enable (master -> RAM)
//   addr  : byte address (master -> RAM)
//   wdata : write data   (master -> RAM)
//   rdata : read data    (RAM -> master)
interface ram_bus_if;
    import ram_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/ram_copy_engine.sv
// Block copy engine for the banked byte RAM. Copies len bytes from
// src_addr to dst_addr, choosing descending order when the destination
// overlaps the tail of the source so the result equals the original data.
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, sampled only in IDLE
//   src_addr/dst_addr : first source/destination byte
//   len               : byte count, 0..32768
//   busy/done/err     : status; done/err are one-cycle pulses
//   mem               : RAM port (master side)
module ram_copy_engine
    import ram_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    ram_bus_if.master         mem
);

    localparam int unsigned SUM_W  = LEN_W + 1;
    localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   off_q, off_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                desc_q, desc_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    ram_req_t            req_q, req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [SUM_W-1:0]    src_end_c;
    logic [SUM_W-1:0]    dst_end_c;
    logic                overlap_c;

    // Range check and overlap detection on the raw request.
    assign src_end_c = SUM_W'(src_addr) + SUM_W'(len);
    assign dst_end_c = SUM_W'(dst_addr) + SUM_W'(len);
    assign overlap_c = (dst_addr > src_addr) && (SUM_W'(dst_addr) < src_end_c);

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            off_q   <= '0;
            rem_q   <= '0;
            desc_q  <= 1'b0;
            wait_q  <= '0;
            req_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            off_q   <= off_d;
            rem_q   <= rem_d;
            desc_q  <= desc_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state; RAM request registers are loaded for the state being entered.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        off_d   = off_q;
        rem_d   = rem_q;
        desc_d  = desc_q;
        wait_d  = wait_q;
        req_d   = req_q;
        req_d.we = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = len;
                    if ((src_end_c > SUM_W'(MEM_BYTES)) || (dst_end_c > SUM_W'(MEM_BYTES))) begin
                        state_d = ERR;
                    end else if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        desc_d     = overlap_c;
                        off_d      = overlap_c ? ADDR_W'(len - LEN_W'(1)) : '0;
                        req_d.addr = src_addr + off_d;
                        busy_d     = 1'b1;
                        state_d    = RD;
                    end
                end
            end
            RD: begin
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Read data is captured straight into the write-data register.
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    req_d.we    = 1'b1;
                    req_d.addr  = dst_q + off_q;
                    req_d.wdata = mem.rdata;
                    state_d     = WR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WR: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    off_d      = desc_q ? (off_q - ADDR_W'(1)) : (off_q + ADDR_W'(1));
                    req_d.addr = src_q + off_d;
                    state_d    = RD;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem.we    = req_q.we;
    assign mem.addr  = req_q.addr;
    assign mem.wdata = req_q.wdata;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench: the copy engine paired with a behavioural banked RAM
// (synchronous read, latency 1) plus a side port for preloading contents.
module tb_ram_copy_engine;
    import ram_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;

    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    ram_bus_if bus ();

    ram_copy_engine #(.RD_LAT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .mem      (bus)
    );

    logic [DATA_W-1:0] ram [0:MEM_BYTES-1];

    always @(posedge clk) begin
        if (bus.we) ram[bus.addr] <= bus.wdata;
        else if (pre_we) ram[pre_addr] <= pre_data;
        bus.rdata <= ram[bus.addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wr_log [$];
    logic [ADDR_W-1:0] addr_log [0:511];
    logic [ADDR_W-1:0] first_addr;
    int                we_total;
    bit                busy_seen;
    bit                saw_done;
    bit                saw_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Present one request; returns #1 after the edge that samples it.
    task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [LEN_W-1:0] l, input bit churn);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        first_addr = bus.addr;
        if (churn) begin
            src_addr = 15'h0010;
            dst_addr = 15'h7000;
            len      = 16'd2;
        end
    endtask

    // Observe cycles after the start edge until done/err or the budget runs out.
    task automatic run(input int max_cyc, input bit churn, output int end_cyc);
        int cyc;
        cyc       = 0;
        end_cyc   = -1;
        we_total  = 0;
        busy_seen = busy;
        saw_done  = 1'b0;
        saw_err   = 1'b0;
        wr_log.delete();
        while (cyc < max_cyc && end_cyc < 0) begin
            start = churn;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc < 512) addr_log[cyc] = bus.addr;
            if (bus.we) begin
                we_total++;
                wr_log.push_back(bus.addr);
            end
            if (busy) busy_seen = 1'b1;
            if (done || err) begin
                saw_done = done;
                saw_err  = err;
                end_cyc  = cyc;
            end
        end
        start = 1'b0;
        if (end_cyc < 0) check_eq("run_timeout", 32'd1, 32'd0);
    endtask

    int ec;
    int extra_done;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_done",  32'(done), 32'd0);
        check_eq("rst_err",   32'(err), 32'd0);
        check_eq("rst_we",    32'(bus.we), 32'd0);
        check_eq("rst_addr",  32'(bus.addr), 32'd0);
        check_eq("rst_wdata", 32'(bus.wdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Plain ascending copy across banks 0 -> 16.
        preload(15'h0100, 8'h11);
        preload(15'h0101, 8'h22);
        preload(15'h0102, 8'h33);
        preload(15'h0103, 8'h44);
        kick(15'h0100, 15'h4000, 16'd4, 1'b0);
        check_eq("t1_first_rd", 32'(first_addr), 32'h0100);
        run(200, 1'b0, ec);
        check_eq("t1_done_cyc", 32'(ec), 32'd13);
        check_eq("t1_done",     32'(saw_done), 32'd1);
        check_eq("t1_we_cnt",   32'(we_total), 32'd4);
        check_eq("t1_d0", 32'(ram[15'h4000]), 32'h11);
        check_eq("t1_d1", 32'(ram[15'h4001]), 32'h22);
        check_eq("t1_d2", 32'(ram[15'h4002]), 32'h33);
        check_eq("t1_d3", 32'(ram[15'h4003]), 32'h44);
        check_eq("t1_busy_after", 32'(busy), 32'd0);

        // Forward overlap: must copy descending.
        for (int i = 0; i < 8; i++) preload(ADDR_W'(16 + i), DATA_W'(i));
        kick(15'h0010, 15'h0012, 16'd6, 1'b0);
        check_eq("t2_first_rd", 32'(first_addr), 32'h0015);
        run(200, 1'b0, ec);
        check_eq("t2_done_cyc", 32'(ec), 32'd19);
        check_eq("t2_first_wr", 32'(wr_log[0]), 32'h0017);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("t2_d%0d", i), 32'(ram[ADDR_W'(18 + i)]), 32'(i));
        check_eq("t2_keep0", 32'(ram[15'h0010]), 32'd0);
        check_eq("t2_keep1", 32'(ram[15'h0011]), 32'd1);

        // Bank crossing on both read and write side.
        preload(15'h03FE, 8'hA1);
        preload(15'h03FF, 8'hA2);
        preload(15'h0400, 8'hA3);
        preload(15'h0401, 8'hA4);
        kick(15'h03FE, 15'h7BFE, 16'd4, 1'b0);
        run(200, 1'b0, ec);
        check_eq("t3_done_cyc", 32'(ec), 32'd13);
        check_eq("t3_rd1_bank", 32'(bank_sel(addr_log[3])), 32'h00);
        check_eq("t3_rd2_bank", 32'(bank_sel(addr_log[6])), 32'h01);
        check_eq("t3_rd2_addr", 32'(addr_log[6]), 32'h0400);
        check_eq("t3_wr1_bank", 32'(bank_sel(wr_log[1])), 32'h1E);
        check_eq("t3_wr2_bank", 32'(bank_sel(wr_log[2])), 32'h1F);
        check_eq("t3_d0", 32'(ram[15'h7BFE]), 32'hA1);
        check_eq("t3_d1", 32'(ram[15'h7BFF]), 32'hA2);
        check_eq("t3_d2", 32'(ram[15'h7C00]), 32'hA3);
        check_eq("t3_d3", 32'(ram[15'h7C01]), 32'hA4);

        // Out-of-range source: rejected, no write, never busy.
        kick(15'h7FFF, 15'h0000, 16'd2, 1'b0);
        run(50, 1'b0, ec);
        check_eq("t4_err_cyc", 32'(ec), 32'd1);
        check_eq("t4_err",     32'(saw_err), 32'd1);
        check_eq("t4_no_done", 32'(saw_done), 32'd0);
        check_eq("t4_we_cnt",  32'(we_total), 32'd0);
        check_eq("t4_busy",    32'(busy_seen), 32'd0);

        // Zero length: immediate done, nothing touched.
        kick(15'h0100, 15'h0200, 16'd0, 1'b0);
        run(50, 1'b0, ec);
        check_eq("t4z_done_cyc", 32'(ec), 32'd1);
        check_eq("t4z_done",     32'(saw_done), 32'd1);
        check_eq("t4z_we_cnt",   32'(we_total), 32'd0);
        check_eq("t4z_busy",     32'(busy_seen), 32'd0);

        // Source ending exactly at the top of memory is legal.
        preload(15'h7FFE, 8'h5A);
        preload(15'h7FFF, 8'hA5);
        kick(15'h7FFE, 15'h0000, 16'd2, 1'b0);
        run(100, 1'b0, ec);
        check_eq("t4e_done_cyc", 32'(ec), 32'd7);
        check_eq("t4e_err",      32'(saw_err), 32'd0);
        check_eq("t4e_d0", 32'(ram[15'h0000]), 32'h5A);
        check_eq("t4e_d1", 32'(ram[15'h0001]), 32'hA5);

        // Reset in the middle of a long copy.
        for (int i = 0; i < 4; i++) preload(ADDR_W'(16'h1000 + i), DATA_W'(8'hC0 + i));
        kick(15'h1000, 15'h2000, 16'd100, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t5_we",   32'(bus.we), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t5_kept%0d", i), 32'(ram[ADDR_W'(16'h2000 + i)]), 32'(8'hC0 + i));
        extra_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check_eq("t5_quiet", 32'(extra_done), 32'd0);
        kick(15'h0100, 15'h5000, 16'd4, 1'b0);
        run(200, 1'b0, ec);
        check_eq("t5_re_done_cyc", 32'(ec), 32'd13);
        check_eq("t5_re_d3", 32'(ram[15'h5003]), 32'h44);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        src_addr = 15'h0100;
        dst_addr = 15'h6100;
        len      = 16'd4;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5b_busy", 32'(busy), 32'd0);

        // Repeated start and changing inputs while busy.
        kick(15'h0100, 15'h6000, 16'd4, 1'b1);
        run(200, 1'b1, ec);
        check_eq("t6_done_cyc", 32'(ec), 32'd13);
        check_eq("t6_we_cnt",   32'(we_total), 32'd4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t6_wr%0d", i), 32'(wr_log[i]), 32'(15'h6000 + i));
        check_eq("t6_d2", 32'(ram[15'h6002]), 32'h33);
        extra_done = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check_eq("t6_one_done", 32'(extra_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
